// File: rtl/shared_memory_initiator_if.sv
// Host-side interface of shared_memory_initiator.
// Groups the command channel (cmd_*), the write beat stream (wr_*) and the
// read return stream (rd_*). The controller uses the master modport and the
// initiator uses the slave modport.
interface shared_memory_initiator_if #(
  parameter int unsigned VEC_W = 16
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [1:0]       cmd_unit;
  logic [3:0]       cmd_len;
  logic             wr_valid;
  logic             wr_ready;
  logic [VEC_W-1:0] wr_vec_data;
  logic [1:0]       wr_mat_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [VEC_W-1:0] rd_vec_data;
  logic [1:0]       rd_mat_data;
  logic             rd_last;

  modport master (
    output cmd_valid, cmd_op, cmd_unit, cmd_len,
    output wr_valid, wr_vec_data, wr_mat_data,
    output rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_vec_data, rd_mat_data, rd_last
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_unit, cmd_len,
    input  wr_valid, wr_vec_data, wr_mat_data,
    input  rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_vec_data, rd_mat_data, rd_last
  );
endinterface

// File: rtl/shared_memory_initiator.sv
// shared_memory_initiator
// Command-driven initiator and sole master of shared_memory_unit ports A
// (vector words, addr {unit, idx}) and B (matrix entries, addr {row, col}).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   host            slave side of the cmd/wr/rd host interface
//   mem_*_a         registered port A controls, mem_rdata_a from data_out_a
//   mem_*_b         registered port B controls, mem_rdata_b from data_out_b
//   mem_error       memory error status, sticky per command into done_err
//   busy            high outside IDLE
//   done, done_err  one-cycle completion pulse and its error flag
module shared_memory_initiator #(
  parameter int unsigned VEC_W         = 16,
  parameter int unsigned RD_FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  shared_memory_initiator_if.slave host,
  output logic [5:0]       mem_addr_a,
  output logic             mem_we_a,
  output logic [VEC_W-1:0] mem_wdata_a,
  input  logic [VEC_W-1:0] mem_rdata_a,
  output logic [7:0]       mem_addr_b,
  output logic             mem_we_b,
  output logic [1:0]       mem_wdata_b,
  input  logic [1:0]       mem_rdata_b,
  input  logic [1:0]       mem_error,
  output logic             busy,
  output logic             done,
  output logic             done_err
);

  localparam int unsigned PW = $clog2(RD_FIFO_DEPTH);
  localparam int unsigned OW = PW + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             is_mat_q, is_mat_d;
  logic [1:0]       unit_q, unit_d;
  logic [3:0]       len_q, len_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [5:0]       addr_a_q, addr_a_d;
  logic             we_a_q, we_a_d;
  logic [VEC_W-1:0] wdata_a_q, wdata_a_d;
  logic [7:0]       addr_b_q, addr_b_d;
  logic             we_b_q, we_b_d;
  logic [1:0]       wdata_b_q, wdata_b_d;

  // Read pipeline: v1 = address on the bus this cycle, v2 = memory data
  // valid this cycle (captured into the FIFO at the end of it).
  logic             v1_q, v1_d, v2_q, v2_d;
  logic             l1_q, l1_d, l2_q, l2_d;

  logic [VEC_W:0]   fifo_mem_q [RD_FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      fifo_cnt_q, fifo_cnt_d;

  logic             last_beat;
  logic             room;
  logic [OW-1:0]    occupancy;
  logic             fifo_nonempty;
  logic             push, pop;
  logic [VEC_W-1:0] push_data;
  logic [VEC_W:0]   head;

  always_comb begin
    last_beat     = is_mat_q ? (cnt_q == 8'hFF) : (cnt_q[3:0] == len_q);
    // FIFO entries plus words still in flight must fit, so no returned word
    // can ever arrive without a free slot regardless of rd_ready.
    occupancy     = OW'(fifo_cnt_q) + OW'(v1_q) + OW'(v2_q);
    room          = occupancy < OW'(RD_FIFO_DEPTH);
    fifo_nonempty = fifo_cnt_q != '0;
    push          = v2_q;
    pop           = fifo_nonempty && host.rd_ready;
    push_data     = '0;
    if (is_mat_q) push_data[1:0] = mem_rdata_b;
    else          push_data      = mem_rdata_a;
    head          = fifo_mem_q[rd_ptr_q];
  end

  always_comb begin
    state_d   = state_q;
    is_mat_d  = is_mat_q;
    unit_d    = unit_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    addr_a_d  = addr_a_q;
    we_a_d    = 1'b0;
    wdata_a_d = wdata_a_q;
    addr_b_d  = addr_b_q;
    we_b_d    = 1'b0;
    wdata_b_d = wdata_b_q;
    v1_d      = 1'b0;
    l1_d      = 1'b0;
    v2_d      = v1_q;
    l2_d      = l1_q;

    if (state_q != S_IDLE && mem_error != 2'b00) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (host.cmd_valid) begin
          is_mat_d = host.cmd_op[1];
          unit_d   = host.cmd_unit;
          len_d    = host.cmd_len;
          cnt_d    = '0;
          err_d    = 1'b0;
          state_d  = host.cmd_op[0] ? S_READ : S_WRITE;
        end
      end
      S_WRITE: begin
        if (host.wr_valid) begin
          if (is_mat_q) begin
            addr_b_d  = cnt_q;
            we_b_d    = 1'b1;
            wdata_b_d = host.wr_mat_data;
          end else begin
            addr_a_d  = {unit_q, cnt_q[3:0]};
            we_a_d    = 1'b1;
            wdata_a_d = host.wr_vec_data;
          end
          cnt_d = cnt_q + 8'd1;
          if (last_beat) state_d = S_DONE;
        end
      end
      S_READ: begin
        if (room) begin
          if (is_mat_q) addr_b_d = cnt_q;
          else          addr_a_d = {unit_q, cnt_q[3:0]};
          v1_d  = 1'b1;
          l1_d  = last_beat;
          cnt_d = cnt_q + 8'd1;
          if (last_beat) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!fifo_nonempty && !v1_q && !v2_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_mat_q   <= 1'b0;
      unit_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      addr_a_q   <= '0;
      we_a_q     <= 1'b0;
      wdata_a_q  <= '0;
      addr_b_q   <= '0;
      we_b_q     <= 1'b0;
      wdata_b_q  <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      l1_q       <= 1'b0;
      l2_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      is_mat_q   <= is_mat_d;
      unit_q     <= unit_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      addr_a_q   <= addr_a_d;
      we_a_q     <= we_a_d;
      wdata_a_q  <= wdata_a_d;
      addr_b_q   <= addr_b_d;
      we_b_q     <= we_b_d;
      wdata_b_q  <= wdata_b_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      l1_q       <= l1_d;
      l2_q       <= l2_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Storage only; validity is tracked by the reset pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {l2_q, push_data};
  end

  always_comb begin
    mem_addr_a       = addr_a_q;
    mem_we_a         = we_a_q;
    mem_wdata_a      = wdata_a_q;
    mem_addr_b       = addr_b_q;
    mem_we_b         = we_b_q;
    mem_wdata_b      = wdata_b_q;
    busy             = state_q != S_IDLE;
    done             = state_q == S_DONE;
    done_err         = (state_q == S_DONE) && err_q;
    host.cmd_ready   = state_q == S_IDLE;
    host.wr_ready    = state_q == S_WRITE;
    host.rd_valid    = fifo_nonempty;
    host.rd_last     = fifo_nonempty && head[VEC_W];
    host.rd_vec_data = (fifo_nonempty && !is_mat_q) ? head[VEC_W-1:0] : '0;
    host.rd_mat_data = (fifo_nonempty && is_mat_q) ? head[1:0] : '0;
  end

endmodule

// File: tb/tb_shared_memory_initiator.sv
module tb_shared_memory_initiator;
  localparam int unsigned VEC_W = 16;

  logic             clk;
  logic             rst;
  logic [5:0]       mem_addr_a;
  logic             mem_we_a;
  logic [VEC_W-1:0] mem_wdata_a;
  logic [VEC_W-1:0] mem_rdata_a;
  logic [7:0]       mem_addr_b;
  logic             mem_we_b;
  logic [1:0]       mem_wdata_b;
  logic [1:0]       mem_rdata_b;
  logic [1:0]       mem_error;
  logic             busy, done, done_err;

  shared_memory_initiator_if #(.VEC_W(VEC_W)) hif ();

  shared_memory_initiator #(.VEC_W(VEC_W), .RD_FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .host(hif.slave),
    .mem_addr_a(mem_addr_a), .mem_we_a(mem_we_a), .mem_wdata_a(mem_wdata_a),
    .mem_rdata_a(mem_rdata_a),
    .mem_addr_b(mem_addr_b), .mem_we_b(mem_we_b), .mem_wdata_b(mem_wdata_b),
    .mem_rdata_b(mem_rdata_b),
    .mem_error(mem_error), .busy(busy), .done(done), .done_err(done_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory model, read-first, one cycle read latency.
  logic [VEC_W-1:0] mem_a [64];
  logic [1:0]       mem_b [256];
  always @(posedge clk) begin
    if (mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
    if (mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
    mem_rdata_a <= mem_a[mem_addr_a];
    mem_rdata_b <= mem_b[mem_addr_b];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Monitors
  int         we_a_cnt = 0, we_b_cnt = 0, done_cnt = 0, chg_b = 0;
  logic [5:0] a_addrs [$];
  logic [7:0] b_addrs [$];
  logic       last_done_err;
  logic       both_we = 1'b0;
  logic [7:0] prev_b = '0;

  always @(negedge clk) begin
    if (mem_we_a) begin we_a_cnt++; a_addrs.push_back(mem_addr_a); end
    if (mem_we_b) begin we_b_cnt++; b_addrs.push_back(mem_addr_b); end
    if (mem_we_a && mem_we_b) both_we = 1'b1;
    if (done) begin done_cnt++; last_done_err = done_err; end
    if (mem_addr_b !== prev_b) chg_b++;
    prev_b = mem_addr_b;
  end

  function automatic logic [1:0] mat_val(int i);
    return 2'((i * 3) + (i >> 4));
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [1:0] unit, input logic [3:0] len);
    n_checks++;
    if (hif.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL cmd_ready_before_cmd: got %b want 1", hif.cmd_ready);
    end
    hif.cmd_valid = 1'b1; hif.cmd_op = op; hif.cmd_unit = unit; hif.cmd_len = len;
    step();
    hif.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, input int bound, input string name);
    int k;
    k = 0;
    while (done_cnt == start && k < bound) begin step(); k++; end
    step();
    n_checks++;
    if (done_cnt != start + 1) begin
      n_fail++; $display("FAIL %s_done_count: got %0d want %0d", name, done_cnt - start, 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    n_checks++;
    if ({hif.cmd_ready, busy, done, done_err, hif.rd_valid, hif.wr_ready, mem_we_a, mem_we_b} !== 8'b1000_0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 10000000",
        {hif.cmd_ready, busy, done, done_err, hif.rd_valid, hif.wr_ready, mem_we_a, mem_we_b});
    end
    n_checks++;
    if ({mem_addr_a, mem_addr_b, mem_wdata_a, mem_wdata_b, hif.rd_vec_data, hif.rd_mat_data, hif.rd_last} !== '0) begin
      n_fail++; $display("FAIL reset_data: addr_a %h addr_b %h rd_vec %h want all 0",
        mem_addr_a, mem_addr_b, hif.rd_vec_data);
    end
    rst = 1'b0; step();
  endtask

  task automatic test_wr_vec();
    int d0, beats, k;
    logic hs;
    logic ok;
    a_addrs.delete(); we_a_cnt = 0; d0 = done_cnt;
    send_cmd(2'b00, 2'd2, 4'd3);
    beats = 0; k = 0;
    while (beats < 4 && k < 40) begin
      hif.wr_valid = 1'b1; hif.wr_vec_data = 16'hA000 + 16'(beats);
      hs = hif.wr_valid && hif.wr_ready;
      step(); k++;
      if (hs) beats++;
    end
    hif.wr_valid = 1'b0;
    wait_done(d0, 20, "wr_vec");
    n_checks++;
    if (we_a_cnt != 4) begin n_fail++; $display("FAIL wr_vec_we_count: got %0d want 4", we_a_cnt); end
    ok = (a_addrs.size() == 4);
    for (int i = 0; i < 4 && ok; i++) if (a_addrs[i] !== 6'(32 + i)) ok = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL wr_vec_addrs: got %p want 0x20..0x23", a_addrs); end
    n_checks++;
    if ({mem_a[32], mem_a[33], mem_a[34], mem_a[35]} !== {16'hA000, 16'hA001, 16'hA002, 16'hA003}) begin
      n_fail++; $display("FAIL wr_vec_mem: got %h %h %h %h want a000..a003", mem_a[32], mem_a[33], mem_a[34], mem_a[35]);
    end
    n_checks++;
    if (last_done_err !== 1'b0) begin n_fail++; $display("FAIL wr_vec_done_err: got %b want 0", last_done_err); end
  endtask

  task automatic test_rd_vec();
    int d0, lat, beats, k, lasts;
    hif.rd_ready = 1'b1; d0 = done_cnt;
    send_cmd(2'b01, 2'd2, 4'd3);
    lat = 0;
    while (!hif.rd_valid && lat < 20) begin step(); lat++; end
    n_checks++;
    if (lat != 3) begin n_fail++; $display("FAIL rd_vec_latency: got %0d want 3", lat); end
    beats = 0; k = 0; lasts = 0;
    while (beats < 4 && k < 40) begin
      if (hif.rd_valid && hif.rd_ready) begin
        n_checks++;
        if (hif.rd_vec_data !== 16'hA000 + 16'(beats) || hif.rd_mat_data !== 2'b00 ||
            hif.rd_last !== (beats == 3)) begin
          n_fail++; $display("FAIL rd_vec_beat%0d: got data %h mat %b last %b want %h 00 %b",
            beats, hif.rd_vec_data, hif.rd_mat_data, hif.rd_last, 16'hA000 + 16'(beats), beats == 3);
        end
        beats++;
      end
      step(); k++;
    end
    n_checks++;
    if (beats != 4) begin n_fail++; $display("FAIL rd_vec_beats: got %0d want 4", beats); end
    wait_done(d0, 20, "rd_vec");
  endtask

  task automatic test_wr_mat();
    int d0, beats, k;
    logic hs, ok;
    b_addrs.delete(); we_b_cnt = 0; we_a_cnt = 0; d0 = done_cnt;
    send_cmd(2'b10, 2'd0, 4'd0);
    beats = 0; k = 0;
    while (beats < 256 && k < 1000) begin
      hif.wr_valid = k[0] ? 1'b0 : 1'b1;
      hif.wr_mat_data = mat_val(beats);
      hs = hif.wr_valid && hif.wr_ready;
      step(); k++;
      if (hs) beats++;
    end
    hif.wr_valid = 1'b0;
    wait_done(d0, 20, "wr_mat");
    n_checks++;
    if (we_b_cnt != 256 || we_a_cnt != 0) begin
      n_fail++; $display("FAIL wr_mat_we_count: got b %0d a %0d want 256 0", we_b_cnt, we_a_cnt);
    end
    ok = (b_addrs.size() == 256);
    for (int i = 0; i < 256 && ok; i++) if (b_addrs[i] !== 8'(i) || mem_b[i] !== mat_val(i)) ok = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL wr_mat_addr_data: got %0d addresses or bad content want 0x00..0xFF", b_addrs.size()); end
    step();
    n_checks++;
    if (done_cnt != d0 + 1) begin n_fail++; $display("FAIL wr_mat_single_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_rd_mat();
    int d0, c0, beats, k, lasts, bad;
    hif.rd_ready = 1'b0; d0 = done_cnt;
    send_cmd(2'b11, 2'd0, 4'd0);
    c0 = chg_b;
    repeat (20) step();
    n_checks++;
    if (chg_b - c0 > 4 || chg_b - c0 < 1) begin
      n_fail++; $display("FAIL rd_mat_stall_issue: got %0d addresses want 1..4", chg_b - c0);
    end
    n_checks++;
    if (hif.rd_valid !== 1'b1) begin n_fail++; $display("FAIL rd_mat_stall_valid: got %b want 1", hif.rd_valid); end
    hif.rd_ready = 1'b1;
    beats = 0; k = 0; lasts = 0; bad = 0;
    while (beats < 256 && k < 1000) begin
      if (hif.rd_valid) begin
        if (hif.rd_mat_data !== mat_val(beats) || hif.rd_vec_data !== '0) bad++;
        if (hif.rd_last) begin
          lasts++;
          if (beats != 255) bad++;
        end
        beats++;
      end
      step(); k++;
    end
    n_checks++;
    if (beats != 256 || bad != 0) begin
      n_fail++; $display("FAIL rd_mat_beats: got %0d beats %0d bad want 256 0", beats, bad);
    end
    n_checks++;
    if (lasts != 1) begin n_fail++; $display("FAIL rd_mat_last_count: got %0d want 1", lasts); end
    wait_done(d0, 20, "rd_mat");
  endtask

  task automatic test_error();
    int d0, beats, k;
    logic hs;
    d0 = done_cnt;
    send_cmd(2'b00, 2'd1, 4'd7);
    beats = 0; k = 0;
    while (beats < 8 && k < 40) begin
      hif.wr_valid = 1'b1; hif.wr_vec_data = 16'h5500 + 16'(beats);
      mem_error = (beats == 3) ? 2'b01 : 2'b00;
      hs = hif.wr_valid && hif.wr_ready;
      step(); k++;
      if (hs) beats++;
    end
    hif.wr_valid = 1'b0; mem_error = 2'b00;
    wait_done(d0, 20, "err_wr");
    n_checks++;
    if (last_done_err !== 1'b1) begin n_fail++; $display("FAIL err_done_err: got %b want 1", last_done_err); end
    n_checks++;
    if (mem_a[16 + 7] !== 16'h5507) begin n_fail++; $display("FAIL err_write_complete: got %h want 5507", mem_a[23]); end
    d0 = done_cnt; hif.rd_ready = 1'b1;
    send_cmd(2'b01, 2'd1, 4'd1);
    wait_done(d0, 30, "err_next");
    n_checks++;
    if (last_done_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", last_done_err); end
  endtask

  task automatic test_reset_mid();
    int d0, beats, k;
    hif.rd_ready = 1'b1; d0 = done_cnt;
    send_cmd(2'b01, 2'd0, 4'd15);
    beats = 0; k = 0;
    while (beats < 5 && k < 40) begin
      if (hif.rd_valid) beats++;
      step(); k++;
    end
    rst = 1'b1; step(); rst = 1'b0;
    n_checks++;
    if ({mem_we_a, mem_we_b, hif.rd_valid, hif.cmd_ready, busy} !== 5'b00010) begin
      n_fail++; $display("FAIL rstmid_state: got we_a/we_b/rd_valid/cmd_ready/busy %b want 00010",
        {mem_we_a, mem_we_b, hif.rd_valid, hif.cmd_ready, busy});
    end
    repeat (10) step();
    n_checks++;
    if (done_cnt != d0 || hif.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_no_done: got done %0d rd_valid %b want 0 0", done_cnt - d0, hif.rd_valid);
    end
    d0 = done_cnt;
    send_cmd(2'b00, 2'd3, 4'd1);
    hif.wr_valid = 1'b1; hif.wr_vec_data = 16'h0C0C;
    step(); step();
    hif.wr_valid = 1'b0;
    wait_done(d0, 20, "rstmid_new");
    n_checks++;
    if (last_done_err !== 1'b0 || mem_a[49] !== 16'h0C0C) begin
      n_fail++; $display("FAIL rstmid_new_cmd: got err %b mem %h want 0 0c0c", last_done_err, mem_a[49]);
    end
  endtask

  task automatic test_we_exclusive();
    n_checks++;
    if (both_we !== 1'b0) begin n_fail++; $display("FAIL we_exclusive: got both high %b want 0", both_we); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_a[i] = 16'(i * 257);
    for (int i = 0; i < 256; i++) mem_b[i] = 2'b00;
    rst = 1'b1; mem_error = 2'b00;
    hif.cmd_valid = 1'b0; hif.cmd_op = '0; hif.cmd_unit = '0; hif.cmd_len = '0;
    hif.wr_valid = 1'b0; hif.wr_vec_data = '0; hif.wr_mat_data = '0; hif.rd_ready = 1'b0;
    test_reset();
    test_wr_vec();
    test_rd_vec();
    test_wr_mat();
    test_rd_mat();
    test_error();
    test_reset_mid();
    test_we_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
